// File: rtl/register_tree_pq_pkg.sv
// Shared types and helpers for the register tree priority queue.
// Node layout is a packed struct whose widths come from the instantiating
// module, so it is provided as a macro that expands to the struct body.
`define PQ_NODE_T(KW, DW) struct packed { logic valid; logic [(KW)-1:0] key; logic [(DW)-1:0] data; }

package register_tree_pq_pkg;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    // Keys are zero-extended to this width before comparison.
    localparam int KEY_MAX_W = 64;

    // True when item a strictly outranks item b. An invalid item never
    // outranks anything and a valid item always outranks an invalid one.
    // Equal keys are not "better", so ties never cause a swap.
    function automatic logic better(
        input logic                 a_valid,
        input logic [KEY_MAX_W-1:0] a_key,
        input logic                 b_valid,
        input logic [KEY_MAX_W-1:0] b_key,
        input logic                 max_first
    );
        if (!a_valid) return 1'b0;
        if (!b_valid) return 1'b1;
        return max_first ? (a_key > b_key) : (a_key < b_key);
    endfunction

    // Tree level of a node in heap order (root is index 0, level 0).
    function automatic int node_level(input int idx);
        int lvl;
        lvl = 0;
        for (int b = 1; b < 31; b++) begin
            if ((idx + 1) >= (1 << b)) lvl = b;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/register_tree_pq_cas_node.sv
// Combinational three-way compare-and-swap of one parent and its two
// children. The better child (left wins a tie) replaces the parent only if
// it strictly outranks it; the displaced parent moves into that child slot.
module pq_cas_node
    import register_tree_pq_pkg::*;
#(
    parameter int KEY_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_FIRST  = 0,
    localparam int NODE_W    = 1 + KEY_WIDTH + DATA_WIDTH
) (
    input  logic [NODE_W-1:0] i_parent,
    input  logic [NODE_W-1:0] i_left,
    input  logic [NODE_W-1:0] i_right,
    output logic [NODE_W-1:0] o_parent,
    output logic [NODE_W-1:0] o_left,
    output logic [NODE_W-1:0] o_right
);
    typedef `PQ_NODE_T(KEY_WIDTH, DATA_WIDTH) node_t;

    node_t w_p, w_l, w_r, w_c;
    logic  w_sel_r;
    logic  w_swap;

    assign w_p = i_parent;
    assign w_l = i_left;
    assign w_r = i_right;

    assign w_sel_r = better(w_r.valid, KEY_MAX_W'(w_r.key),
                            w_l.valid, KEY_MAX_W'(w_l.key), MAX_FIRST != 0);
    assign w_c     = w_sel_r ? w_r : w_l;
    assign w_swap  = better(w_c.valid, KEY_MAX_W'(w_c.key),
                            w_p.valid, KEY_MAX_W'(w_p.key), MAX_FIRST != 0);

    // Swap the parent with its best child when that child outranks it.
    always_comb begin
        o_parent = i_parent;
        o_left   = i_left;
        o_right  = i_right;
        if (w_swap) begin
            o_parent = w_c;
            if (w_sel_r) o_right = w_p;
            else         o_left  = w_p;
        end
    end

endmodule

// File: rtl/register_tree_pq.sv
// Register tree priority queue: N = 2^LEVELS-1 registered nodes in heap
// order (children of i are 2i+1, 2i+2). Pushes land in a free leaf, pops
// take the root, and idle cycles run odd/even level compare-and-swap so the
// best item rises to the root. LEVELS must be at least 2.
// Handshake: a push transfers when i_push_valid & o_push_ready at the clock
// edge; a pop transfers when o_pop_valid & i_pop_ready. Both together
// replace the root with the pushed item.
module register_tree_pq
    import register_tree_pq_pkg::*;
#(
    parameter int LEVELS     = 3,
    parameter int KEY_WIDTH  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_FIRST  = 0,
    localparam int N         = (1 << LEVELS) - 1,
    localparam int CW        = $clog2(N + 1)
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  i_flush,
    input  logic                  i_push_valid,
    output logic                  o_push_ready,
    input  logic [KEY_WIDTH-1:0]  i_push_key,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    output logic                  o_pop_valid,
    input  logic                  i_pop_ready,
    output logic [KEY_WIDTH-1:0]  o_pop_key,
    output logic [DATA_WIDTH-1:0] o_pop_data,
    output logic [CW-1:0]         o_count,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int N_INT  = (1 << (LEVELS - 1)) - 1;
    localparam int N_LEAF = N - N_INT;
    localparam int IW     = $clog2(N);
    localparam int SW     = $clog2(2 * LEVELS + 1);
    localparam logic [SW-1:0] SETTLE_RELOAD = SW'(2 * LEVELS);

    typedef `PQ_NODE_T(KEY_WIDTH, DATA_WIDTH) node_t;

    node_t          r_node [N];
    node_t          w_node_nxt [N];
    node_t          w_cas_p [N_INT];
    node_t          w_cas_l [N_INT];
    node_t          w_cas_r [N_INT];
    logic [N_INT-1:0] w_cas_en;
    logic [CW-1:0]  r_count;
    logic [SW-1:0]  r_settle;
    phase_t         r_phase;
    logic           w_leaf_free;
    logic [IW-1:0]  w_leaf_idx;
    logic           w_push_fire;
    logic           w_pop_fire;
    logic           w_idle;
    node_t          w_push_node;

    for (genvar g = 0; g < N_INT; g++) begin : g_cas
        pq_cas_node #(
            .KEY_WIDTH  (KEY_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_FIRST  (MAX_FIRST)
        ) u_cas (
            .i_parent (r_node[g]),
            .i_left   (r_node[2*g+1]),
            .i_right  (r_node[2*g+2]),
            .o_parent (w_cas_p[g]),
            .o_left   (w_cas_l[g]),
            .o_right  (w_cas_r[g])
        );
        assign w_cas_en[g] = ((node_level(g) % 2) == 0) == (r_phase == PH_EVEN);
    end

    // Lowest-index invalid leaf; also tells whether any leaf is free.
    always_comb begin
        w_leaf_free = 1'b0;
        w_leaf_idx  = '0;
        for (int j = N_LEAF - 1; j >= 0; j--) begin
            if (!r_node[N_INT + j].valid) begin
                w_leaf_free = 1'b1;
                w_leaf_idx  = IW'(N_INT + j);
            end
        end
    end

    assign o_push_ready = w_leaf_free;
    assign o_pop_valid  = r_node[0].valid && (r_settle == '0);
    assign o_pop_key    = o_pop_valid ? r_node[0].key  : '0;
    assign o_pop_data   = o_pop_valid ? r_node[0].data : '0;
    assign o_count      = r_count;
    assign o_full       = (r_count == CW'(N));
    assign o_empty      = (r_count == '0);

    assign w_push_fire  = i_push_valid && o_push_ready;
    assign w_pop_fire   = o_pop_valid && i_pop_ready;
    assign w_idle       = !i_flush && !w_push_fire && !w_pop_fire;
    assign w_push_node  = '{valid: 1'b1, key: i_push_key, data: i_push_data};

    // Next node contents: flush, then push/pop/replace, else one CAS phase.
    always_comb begin
        for (int i = 0; i < N; i++) w_node_nxt[i] = r_node[i];
        if (i_flush) begin
            for (int i = 0; i < N; i++) w_node_nxt[i].valid = 1'b0;
        end else if (w_push_fire && w_pop_fire) begin
            w_node_nxt[0] = w_push_node;
        end else if (w_push_fire) begin
            w_node_nxt[w_leaf_idx] = w_push_node;
        end else if (w_pop_fire) begin
            w_node_nxt[0].valid = 1'b0;
        end else begin
            for (int i = 0; i < N_INT; i++) begin
                if (w_cas_en[i]) begin
                    w_node_nxt[i]       = w_cas_p[i];
                    w_node_nxt[2*i + 1] = w_cas_l[i];
                    w_node_nxt[2*i + 2] = w_cas_r[i];
                end
            end
        end
    end

    // Node storage.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < N; i++) r_node[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) r_node[i] <= w_node_nxt[i];
        end
    end

    // Occupancy count, settle counter and sort phase.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_count  <= '0;
            r_settle <= '0;
            r_phase  <= PH_EVEN;
        end else if (i_flush) begin
            r_count  <= '0;
            r_settle <= '0;
        end else if (w_push_fire || w_pop_fire) begin
            r_settle <= SETTLE_RELOAD;
            if (w_push_fire && !w_pop_fire) r_count <= r_count + CW'(1);
            if (w_pop_fire && !w_push_fire) r_count <= r_count - CW'(1);
        end else if (w_idle) begin
            r_phase <= (r_phase == PH_EVEN) ? PH_ODD : PH_EVEN;
            if (r_settle != '0) r_settle <= r_settle - SW'(1);
        end
    end

endmodule

// File: tb/tb_register_tree_pq.sv
// Bench for register_tree_pq: a min-first and a max-first instance share
// every input, so both see identical traffic and stay in step; a sorted
// expected queue per instance predicts every pop.
module tb_register_tree_pq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        push_valid;
    logic [15:0] push_key;
    logic [15:0] push_data;
    logic        pop_ready;

    logic        m_push_ready, m_pop_valid, m_full, m_empty;
    logic [15:0] m_pop_key, m_pop_data;
    logic [2:0]  m_count;
    logic        x_push_ready, x_pop_valid, x_full, x_empty;
    logic [15:0] x_pop_key, x_pop_data;
    logic [2:0]  x_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];      // min-first expected pop order {key,data}
    logic [31:0] exp_max_q[$];  // max-first expected pop order {key,data}

    typedef struct {
        logic [15:0] key;
        logic [15:0] data;
        int          exp_count;
    } vec_t;

    register_tree_pq #(.LEVELS(3), .KEY_WIDTH(16), .DATA_WIDTH(16), .MAX_FIRST(0)) u_min (
        .CLK(clk), .RSTn(rst_n), .i_flush(flush),
        .i_push_valid(push_valid), .o_push_ready(m_push_ready),
        .i_push_key(push_key), .i_push_data(push_data),
        .o_pop_valid(m_pop_valid), .i_pop_ready(pop_ready),
        .o_pop_key(m_pop_key), .o_pop_data(m_pop_data),
        .o_count(m_count), .o_full(m_full), .o_empty(m_empty)
    );

    register_tree_pq #(.LEVELS(3), .KEY_WIDTH(16), .DATA_WIDTH(16), .MAX_FIRST(1)) u_max (
        .CLK(clk), .RSTn(rst_n), .i_flush(flush),
        .i_push_valid(push_valid), .o_push_ready(x_push_ready),
        .i_push_key(push_key), .i_push_data(push_data),
        .o_pop_valid(x_pop_valid), .i_pop_ready(pop_ready),
        .o_pop_key(x_pop_key), .o_pop_data(x_pop_data),
        .o_count(x_count), .o_full(x_full), .o_empty(x_empty)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Insert into both expected queues at the sorted position (stable on ties).
    task automatic sb_insert(input logic [15:0] k, input logic [15:0] d);
        int pos;
        pos = exp_q.size();
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i][31:16] > k) pos = i;
        exp_q.insert(pos, {k, d});
        pos = exp_max_q.size();
        for (int i = exp_max_q.size() - 1; i >= 0; i--)
            if (exp_max_q[i][31:16] < k) pos = i;
        exp_max_q.insert(pos, {k, d});
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic do_push(input logic [15:0] k, input logic [15:0] d);
        int waited;
        waited = 0;
        push_valid = 1'b1;
        push_key   = k;
        push_data  = d;
        while (!m_push_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!m_push_ready) begin
            check("push_ready_timeout", 32'(m_push_ready), 32'd1);
            push_valid = 1'b0;
            return;
        end
        @(negedge clk);
        push_valid = 1'b0;
        sb_insert(k, d);
        check("count_after_push", 32'(m_count), 32'(exp_q.size()));
    endtask

    task automatic do_pop();
        int waited;
        waited = 0;
        while (!m_pop_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!m_pop_valid || exp_q.size() == 0) begin
            check("pop_valid_timeout", 32'(m_pop_valid), 32'(exp_q.size() != 0));
            return;
        end
        check("min_pop_key",   32'(m_pop_key),   32'(exp_q[0][31:16]));
        check("min_pop_data",  32'(m_pop_data),  32'(exp_q[0][15:0]));
        check("max_pop_valid", 32'(x_pop_valid), 32'd1);
        check("max_pop_key",   32'(x_pop_key),   32'(exp_max_q[0][31:16]));
        check("max_pop_data",  32'(x_pop_data),  32'(exp_max_q[0][15:0]));
        pop_ready = 1'b1;
        @(negedge clk);
        pop_ready = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_max_q.pop_front());
        check("count_after_pop", 32'(m_count), 32'(exp_q.size()));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            do_pop();
            guard++;
        end
        check("empty_after_drain", 32'(m_empty), 32'd1);
        check("max_empty_after_drain", 32'(x_empty), 32'd1);
    endtask

    vec_t sort_vecs[4];
    vec_t max_vecs[3];
    logic [15:0] used_keys[$];
    logic [15:0] rk;

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        push_valid = 1'b0;
        push_key   = '0;
        push_data  = '0;
        pop_ready  = 1'b0;

        sort_vecs[0] = '{16'd9, 16'h00A9, 1};
        sort_vecs[1] = '{16'd4, 16'h00A4, 2};
        sort_vecs[2] = '{16'd7, 16'h00A7, 3};
        sort_vecs[3] = '{16'd1, 16'h00A1, 4};
        max_vecs[0]  = '{16'd3,  16'h0C03, 1};
        max_vecs[1]  = '{16'd12, 16'h0C0C, 2};
        max_vecs[2]  = '{16'd5,  16'h0C05, 3};

        // Reset and idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("reset_empty",      32'(m_empty),      32'd1);
        check("reset_full",       32'(m_full),       32'd0);
        check("reset_pop_valid",  32'(m_pop_valid),  32'd0);
        check("reset_push_ready", 32'(m_push_ready), 32'd1);
        check("reset_count",      32'(m_count),      32'd0);
        check("reset_pop_key",    32'(m_pop_key),    32'd0);
        check("reset_max_empty",  32'(x_empty),      32'd1);

        // Sorted pop order from a table of pushes.
        for (int i = 0; i < 4; i++) begin
            do_push(sort_vecs[i].key, sort_vecs[i].data);
            check("table_count", 32'(m_count), 32'(sort_vecs[i].exp_count));
        end
        drain();

        // Fill to capacity, hold an extra push, pop one, space reopens.
        for (int k = 7; k >= 1; k--) do_push(16'(k), 16'(16'h00B0 + k));
        check("full_flag",        32'(m_full),       32'd1);
        check("full_push_ready",  32'(m_push_ready), 32'd0);
        push_valid = 1'b1;
        push_key   = 16'h0020;
        push_data  = 16'h0E20;
        repeat (8) @(negedge clk);
        check("held_push_count",  32'(m_count),      32'd7);
        check("held_push_ready",  32'(m_push_ready), 32'd0);
        push_valid = 1'b0;
        do_pop();
        check("full_after_pop",   32'(m_full),       32'd0);
        check("count_after_pop6", 32'(m_count),      32'd6);
        begin
            int waited;
            waited = 0;
            while (!m_push_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
        end
        check("ready_after_settle", 32'(m_push_ready), 32'd1);
        drain();

        // Mode comparison on a small table (max instance pops 12,5,3).
        for (int i = 0; i < 3; i++) begin
            do_push(max_vecs[i].key, max_vecs[i].data);
            check("max_table_count", 32'(x_count), 32'(max_vecs[i].exp_count));
        end
        drain();

        // Replace: push and pop in the same cycle.
        do_push(16'd3, 16'h0D03);
        do_push(16'd5, 16'h0D05);
        do_push(16'd8, 16'h0D08);
        begin
            int waited;
            waited = 0;
            while (!m_pop_valid && waited < 50) begin
                @(negedge clk);
                waited++;
            end
        end
        check("replace_root_min", 32'(m_pop_key),    32'(exp_q[0][31:16]));
        check("replace_root_max", 32'(x_pop_key),    32'(exp_max_q[0][31:16]));
        check("replace_ready",    32'(m_push_ready), 32'd1);
        push_valid = 1'b1;
        push_key   = 16'd2;
        push_data  = 16'h0D02;
        pop_ready  = 1'b1;
        @(negedge clk);
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        void'(exp_q.pop_front());
        void'(exp_max_q.pop_front());
        sb_insert(16'd2, 16'h0D02);
        check("replace_count",    32'(m_count), 32'd3);
        drain();

        // Flush wins over a same-cycle push.
        do_push(16'd10, 16'h0F10);
        do_push(16'd20, 16'h0F20);
        do_push(16'd30, 16'h0F30);
        do_push(16'd40, 16'h0F40);
        flush      = 1'b1;
        push_valid = 1'b1;
        push_key   = 16'h0055;
        push_data  = 16'h0F55;
        @(negedge clk);
        flush      = 1'b0;
        push_valid = 1'b0;
        exp_q.delete();
        exp_max_q.delete();
        check("flush_count",     32'(m_count),     32'd0);
        check("flush_empty",     32'(m_empty),     32'd1);
        check("flush_pop_valid", 32'(m_pop_valid), 32'd0);
        repeat (8) @(negedge clk);
        check("flush_push_absent", 32'(m_pop_valid), 32'd0);
        check("flush_count_late",  32'(m_count),     32'd0);

        // Random distinct keys.
        for (int i = 0; i < 6; i++) begin
            rk = 16'($urandom_range(1, 500));
            while (rk inside {used_keys}) rk = 16'($urandom_range(1, 500));
            used_keys.push_back(rk);
            do_push(rk, 16'($urandom_range(0, 16'hFFFF)));
        end
        drain();

        // Asynchronous reset mid-operation.
        do_push(16'd11, 16'h0111);
        do_push(16'd22, 16'h0122);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(m_count),      32'd0);
        check("async_rst_empty", 32'(m_empty),      32'd1);
        check("async_rst_ready", 32'(m_push_ready), 32'd1);
        exp_q.delete();
        exp_max_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_pop_valid", 32'(m_pop_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
